// File: rtl/wb_result_arbiter_pkg.sv
// Shared types and sizing for the write-back result arbiter: result record,
// exception record, source/port counts and per-source FIFO geometry.
package wb_result_arbiter_pkg;

  localparam int TRANS_ID_BITS = 3;
  localparam int NR_WB_SRC     = 5;
  localparam int NR_WB_PORTS   = 2;
  localparam int FIFO_DEPTH    = 2;
  localparam int STORE_SRC     = 2;

  localparam int SRC_IDX_W  = $clog2(NR_WB_SRC);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               ex;
  } wb_result_t;

  // Round-robin successor of a source index, wrapping at NR_WB_SRC.
  function automatic logic [SRC_IDX_W-1:0] next_src(input logic [SRC_IDX_W-1:0] s);
    return (s == SRC_IDX_W'(NR_WB_SRC - 1)) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/wb_result_arbiter_if.sv
// Bundle between the execute-stage result producers, the arbiter and the
// scoreboard write ports.
interface wb_result_arbiter_if;
  import wb_result_arbiter_pkg::*;

  // Handshake: src_valid[s] pushes one record at the clock edge and may only be
  // raised while src_ready[s] is high. wb_valid has no back-pressure; every
  // asserted write port is consumed by the scoreboard in that cycle.
  logic [NR_WB_SRC-1:0]     src_valid;
  logic [NR_WB_SRC-1:0]     src_ready;
  logic [TRANS_ID_BITS-1:0] src_trans_id [NR_WB_SRC];
  logic [63:0]              src_result   [NR_WB_SRC];
  exception_t               src_ex       [NR_WB_SRC];

  logic [NR_WB_PORTS-1:0]   wb_valid;
  logic [TRANS_ID_BITS-1:0] wb_trans_id  [NR_WB_PORTS];
  logic [63:0]              wb_result    [NR_WB_PORTS];
  exception_t               wb_ex        [NR_WB_PORTS];

  modport master (
    output src_valid, src_trans_id, src_result, src_ex,
    input  src_ready, wb_valid, wb_trans_id, wb_result, wb_ex
  );

  modport slave (
    input  src_valid, src_trans_id, src_result, src_ex,
    output src_ready, wb_valid, wb_trans_id, wb_result, wb_ex
  );

endinterface

// File: rtl/wb_result_arbiter_src_fifo.sv
// Small per-source result FIFO with push/pop/flush; the head is read
// combinationally so the arbiter can forward it in the grant cycle.
module wb_result_arbiter_src_fifo
  import wb_result_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  wb_result_t data_i,
  output wb_result_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  wb_result_t              mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0]   wr_ptr;
  logic [FIFO_PTR_W-1:0]   rd_ptr;
  logic [FIFO_CNT_W-1:0]   count;
  logic                    do_push;
  logic                    do_pop;

  assign full_o  = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty_o = (count == '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  push_into_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i))
    else $error("push into full source FIFO");

endmodule

// File: rtl/wb_result_arbiter.sv
// Collects execute-stage results into per-source FIFOs and forwards up to
// NR_WB_PORTS of them per cycle to the scoreboard, round-robin across sources.
module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  wb_result_arbiter_if.slave   bus,
  output logic [SRC_IDX_W-1:0] rr_ptr_o
);

  logic [NR_WB_SRC-1:0]   full;
  logic [NR_WB_SRC-1:0]   empty;
  logic [NR_WB_SRC-1:0]   grant;
  wb_result_t             head [NR_WB_SRC];

  logic [SRC_IDX_W-1:0]   ptr_q;
  logic [SRC_IDX_W-1:0]   ptr_d;
  logic [SRC_IDX_W-1:0]   last_src;
  logic [SRC_IDX_W:0]     scan_sum;
  logic [SRC_IDX_W-1:0]   scan_idx;
  logic                   taken;
  logic [NR_WB_PORTS-1:0] port_vld;
  logic [SRC_IDX_W-1:0]   port_sel [NR_WB_PORTS];

  logic [NR_WB_PORTS-1:0] wb_valid_q;
  wb_result_t             wb_q [NR_WB_PORTS];

  for (genvar s = 0; s < NR_WB_SRC; s++) begin : g_src
    // Committed store acknowledgements must survive a pipeline flush.
    localparam bit FLUSHABLE = (s != STORE_SRC);
    wb_result_t push_data;

    assign push_data = '{trans_id: bus.src_trans_id[s],
                         result:   bus.src_result[s],
                         ex:       bus.src_ex[s]};

    wb_result_arbiter_src_fifo u_fifo (
      .clk_i,
      .rst_ni,
      .flush_i (flush_i && FLUSHABLE),
      .push_i  (bus.src_valid[s]),
      .pop_i   (grant[s]),
      .data_i  (push_data),
      .head_o  (head[s]),
      .full_o  (full[s]),
      .empty_o (empty[s])
    );
  end

  assign bus.src_ready = ~full;

  // Scan from ptr_q; each non-empty source takes the lowest free write port.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    last_src = ptr_q;
    scan_sum = '0;
    scan_idx = '0;
    taken    = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++) port_sel[p] = '0;
    for (int k = 0; k < NR_WB_SRC; k++) begin
      scan_sum = {1'b0, ptr_q} + (SRC_IDX_W+1)'(k);
      if (scan_sum >= (SRC_IDX_W+1)'(NR_WB_SRC)) scan_sum = scan_sum - (SRC_IDX_W+1)'(NR_WB_SRC);
      scan_idx = scan_sum[SRC_IDX_W-1:0];
      taken    = 1'b0;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (!flush_i && !empty[scan_idx] && !port_vld[p] && !taken) begin
          port_vld[p]     = 1'b1;
          port_sel[p]     = scan_idx;
          grant[scan_idx] = 1'b1;
          last_src        = scan_idx;
          taken           = 1'b1;
        end
      end
    end
    ptr_d = ptr_q;
    if (flush_i)        ptr_d = '0;
    else if (|port_vld) ptr_d = next_src(last_src);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      wb_valid_q <= '0;
      for (int p = 0; p < NR_WB_PORTS; p++) wb_q[p] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wb_valid_q <= port_vld;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (port_vld[p]) wb_q[p] <= head[port_sel[p]];
      end
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign rr_ptr_o     = ptr_q;

  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_port
    assign bus.wb_trans_id[p] = wb_q[p].trans_id;
    assign bus.wb_result[p]   = wb_q[p].result;
    assign bus.wb_ex[p]       = wb_q[p].ex;
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Bench for wb_result_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_result_arbiter;
  import wb_result_arbiter_pkg::*;

  localparam int WB_W = $bits(wb_result_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [SRC_IDX_W-1:0] dut_ptr;

  always #5 clk = ~clk;

  wb_result_arbiter_if bus ();

  wb_result_arbiter dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .flush_i  (flush),
    .bus      (bus),
    .rr_ptr_o (dut_ptr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WB_W-1:0]        exp_q[$];
  wb_result_t             mq [NR_WB_SRC][$];
  int                     m_ptr = 0;
  logic [NR_WB_PORTS-1:0] m_valid = '0;
  bit                     mdl_rdy [NR_WB_SRC];
  int                     mdl_n;
  int                     mdl_last;
  int                     mdl_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NR_WB_SRC; s++) mq[s].delete();
      exp_q.delete();
      m_ptr   = 0;
      m_valid = '0;
    end else begin
      for (int s = 0; s < NR_WB_SRC; s++) mdl_rdy[s] = (mq[s].size() < FIFO_DEPTH);
      m_valid  = '0;
      mdl_n    = 0;
      mdl_last = -1;
      if (!flush) begin
        for (int k = 0; k < NR_WB_SRC; k++) begin
          mdl_s = (m_ptr + k) % NR_WB_SRC;
          if (mq[mdl_s].size() > 0 && mdl_n < NR_WB_PORTS) begin
            exp_q.push_back(mq[mdl_s].pop_front());
            m_valid[mdl_n] = 1'b1;
            mdl_n++;
            mdl_last = mdl_s;
          end
        end
        if (mdl_last >= 0) m_ptr = (mdl_last + 1) % NR_WB_SRC;
      end else begin
        for (int s = 0; s < NR_WB_SRC; s++) if (s != STORE_SRC) mq[s].delete();
        m_ptr = 0;
      end
      for (int s = 0; s < NR_WB_SRC; s++) begin
        if (bus.src_valid[s] && mdl_rdy[s] && !(flush && s != STORE_SRC))
          mq[s].push_back(wb_result_t'{trans_id: bus.src_trans_id[s],
                                       result:   bus.src_result[s],
                                       ex:       bus.src_ex[s]});
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [WB_W-1:0]      cmp_exp;
  logic [NR_WB_SRC-1:0] cmp_rdy;

  always @(negedge clk) begin
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      chk($sformatf("wb_valid[%0d]", p), 256'(bus.wb_valid[p]), 256'(m_valid[p]));
      if (m_valid[p] && exp_q.size() > 0) begin
        cmp_exp = exp_q.pop_front();
        if (bus.wb_valid[p])
          chk($sformatf("wb_entry[%0d]", p),
              256'({bus.wb_trans_id[p], bus.wb_result[p], bus.wb_ex[p]}), 256'(cmp_exp));
      end
    end
    for (int s = 0; s < NR_WB_SRC; s++) cmp_rdy[s] = (mq[s].size() < FIFO_DEPTH);
    chk("src_ready", 256'(bus.src_ready), 256'(cmp_rdy));
    chk("rr_ptr", 256'(dut_ptr), 256'(m_ptr));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input int s, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] data);
    bus.src_valid[s]    = 1'b1;
    bus.src_trans_id[s] = id;
    bus.src_result[s]   = data;
    bus.src_ex[s]       = '{cause: 64'h100 + 64'(s), tval: data, valid: (s == 3)};
  endtask

  task automatic clear_src();
    bus.src_valid = '0;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // ---------------- directed scenarios ----------------
  int last_seen [3];
  int max_gap   [3];
  int seen_cnt  [3];
  int stale;
  int id_i;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.src_valid = '0;
    for (int s = 0; s < NR_WB_SRC; s++) begin
      bus.src_trans_id[s] = '0;
      bus.src_result[s]   = '0;
      bus.src_ex[s]       = '0;
    end
    step(2);
    chk("reset wb_valid", 256'(bus.wb_valid), 0);
    chk("reset wb_trans_id0", 256'(bus.wb_trans_id[0]), 0);
    chk("reset wb_result1", 256'(bus.wb_result[1]), 0);
    chk("reset wb_ex0", 256'(bus.wb_ex[0]), 0);
    chk("reset src_ready", 256'(bus.src_ready), 256'(5'b11111));
    rst_n = 1'b1;
    step(1);

    // single result, two-cycle latency
    set_src(0, 3, 64'hDEAD);
    step(1);
    clear_src();
    step(1);
    chk("t1 wb_valid", 256'(bus.wb_valid), 256'(2'b01));
    chk("t1 trans_id", 256'(bus.wb_trans_id[0]), 3);
    chk("t1 result", 256'(bus.wb_result[0]), 256'(64'hDEAD));
    step(2);

    // all five sources at once, pointer forced to 0 by a flush
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("t2 ptr after flush", 256'(dut_ptr), 0);
    for (int s = 0; s < NR_WB_SRC; s++) set_src(s, s[TRANS_ID_BITS-1:0], 64'h200 + 64'(s));
    step(1);
    clear_src();
    step(1);
    chk("t2 c0 valid", 256'(bus.wb_valid), 256'(2'b11));
    chk("t2 c0 id0", 256'(bus.wb_trans_id[0]), 0);
    chk("t2 c0 id1", 256'(bus.wb_trans_id[1]), 1);
    step(1);
    chk("t2 c1 valid", 256'(bus.wb_valid), 256'(2'b11));
    chk("t2 c1 id0", 256'(bus.wb_trans_id[0]), 2);
    chk("t2 c1 id1", 256'(bus.wb_trans_id[1]), 3);
    step(1);
    chk("t2 c2 valid", 256'(bus.wb_valid), 256'(2'b01));
    chk("t2 c2 id0", 256'(bus.wb_trans_id[0]), 4);
    chk("t2 ptr wrapped", 256'(dut_ptr), 0);
    step(1);

    // load FIFO fills under contention and drains in order
    for (int s = 0; s < NR_WB_SRC; s++) set_src(s, s[TRANS_ID_BITS-1:0], 64'h300 + 64'(s));
    step(1);
    for (int s = 0; s < NR_WB_SRC; s++) set_src(s, (s == 1) ? 3'd5 : s[TRANS_ID_BITS-1:0], 64'h310 + 64'(s));
    step(1);
    chk("t3 ready a", 256'(bus.src_ready), 256'(5'b00011));
    clear_src();
    set_src(1, 6, 64'h321);
    step(1);
    clear_src();
    chk("t3 load ready low", 256'(bus.src_ready[1]), 0);
    chk("t3 ready b", 256'(bus.src_ready), 256'(5'b01101));
    chk("t3 out a", 256'({bus.wb_valid, bus.wb_trans_id[0], bus.wb_trans_id[1]}), 256'({2'b11, 3'd2, 3'd3}));
    step(1);
    chk("t3 out b", 256'({bus.wb_valid, bus.wb_trans_id[0], bus.wb_trans_id[1]}), 256'({2'b11, 3'd4, 3'd0}));
    chk("t3 out b data", 256'(bus.wb_result[1]), 256'(64'h310));
    step(1);
    chk("t3 out c", 256'({bus.wb_valid, bus.wb_trans_id[0], bus.wb_trans_id[1]}), 256'({2'b11, 3'd5, 3'd2}));
    chk("t3 load first data", 256'(bus.wb_result[0]), 256'(64'h311));
    step(1);
    chk("t3 out d", 256'({bus.wb_valid, bus.wb_trans_id[0], bus.wb_trans_id[1]}), 256'({2'b11, 3'd3, 3'd4}));
    chk("t3 fpu ex valid", 256'(bus.wb_ex[0].valid), 1);
    step(1);
    chk("t3 out e valid", 256'(bus.wb_valid), 256'(2'b01));
    chk("t3 load second", 256'({bus.wb_trans_id[0], bus.wb_result[0]}), 256'({3'd6, 64'h321}));
    step(2);

    // flush keeps only the store acknowledgement
    set_src(1, 1, 64'h401);
    set_src(2, 7, 64'h407);
    set_src(3, 3, 64'h403);
    step(1);
    clear_src();
    flush = 1'b1;
    set_src(1, 2, 64'h402);
    step(1);
    clear_src();
    flush = 1'b0;
    chk("t4 valid after flush", 256'(bus.wb_valid), 0);
    chk("t4 ptr after flush", 256'(dut_ptr), 0);
    chk("t4 ready after flush", 256'(bus.src_ready), 256'(5'b11111));
    step(1);
    chk("t4 store survives", 256'({bus.wb_valid, bus.wb_trans_id[0], bus.wb_result[0]}), 256'({2'b01, 3'd7, 64'h407}));
    step(1);
    chk("t4 nothing stale", 256'(bus.wb_valid), 0);
    step(1);

    // fairness: sources 0..2 kept busy
    for (int s = 0; s < 3; s++) begin
      last_seen[s] = 0;
      max_gap[s]   = 0;
      seen_cnt[s]  = 0;
    end
    for (int cyc = 1; cyc <= 30; cyc++) begin
      for (int s = 0; s < 3; s++) begin
        if (bus.src_ready[s]) set_src(s, s[TRANS_ID_BITS-1:0], 64'h500 + 64'(cyc));
        else bus.src_valid[s] = 1'b0;
      end
      step(1);
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        id_i = int'(bus.wb_trans_id[p]);
        if (bus.wb_valid[p] && id_i < 3) begin
          if (cyc - last_seen[id_i] > max_gap[id_i]) max_gap[id_i] = cyc - last_seen[id_i];
          last_seen[id_i] = cyc;
          seen_cnt[id_i]++;
        end
      end
    end
    clear_src();
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t5 src%0d served", s), 256'(seen_cnt[s] > 5), 1);
      chk($sformatf("t5 src%0d gap bound", s), 256'(max_gap[s] <= NR_WB_SRC), 1);
    end
    step(6);

    // asynchronous reset mid-drain
    set_src(0, 1, 64'h601);
    set_src(1, 2, 64'h602);
    set_src(3, 3, 64'h603);
    step(1);
    clear_src();
    step(1);
    chk("t6 draining", 256'(bus.wb_valid), 256'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async valid", 256'(bus.wb_valid), 0);
    chk("t6 async id", 256'(bus.wb_trans_id[0]), 0);
    chk("t6 async result", 256'(bus.wb_result[1]), 0);
    chk("t6 async ready", 256'(bus.src_ready), 256'(5'b11111));
    step(1);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (bus.wb_valid != '0) stale++;
    end
    chk("t6 no stale after reset", 256'(stale), 0);

    step(2);
    chk("scoreboard drained", 256'(exp_q.size()), 0);
    summary();
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $finish;
  end

endmodule
